instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
//
// PURPOSE
// - Fetch stage between the program counter and decode.
// - Takes the current PC, issues a valid/ready read to instruction memory,
//   captures the returned word and holds it for decode with valid/ready.
// - Pulses pc_advance when decode accepts the word. pc_advance drives the PC
//   enable bit, so the PC never moves while a fetch is outstanding.
// - Handles flush (redirect), misaligned PC and memory timeout.
//
// PARAMETERS
// - XLEN            32  address and instruction width
// - TIMEOUT_CYCLES  64  max cycles in WAIT before abort; must be >= 2
// - CNT_W           32  width of retired-fetch counter
//
// PORTS
// - clk             in   1      clock
// - reset           in   1      reset, synchronous, active-high
// - pc_in           in   XLEN   current PC, sampled on fetch_go
// - fetch_go        in   1      request a fetch of pc_in
// - flush           in   1      discard current/in-flight fetch
// - imem_req_valid  out  1      memory read request valid
// - imem_req_ready  in   1      memory accepts request
// - imem_req_addr   out  XLEN   word-aligned read address
// - imem_rsp_valid  in   1      read data valid (one beat per accepted req)
// - imem_rsp_data   in   XLEN   read data
// - ir_valid        out  1      instruction valid to decode
// - ir_ready        in   1      decode accepts instruction
// - ir_instr        out  XLEN   captured instruction
// - ir_pc           out  XLEN   PC of ir_instr
// - pc_advance      out  1      1-cycle pulse; PC enable
// - fetch_fault     out  1      1-cycle pulse: misaligned pc_in
// - fetch_timeout   out  1      1-cycle pulse: WAIT exceeded TIMEOUT_CYCLES
// - fetch_count     out  CNT_W  number of retired fetches, wraps at 2^CNT_W
//
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (imem_req_addr, ir_instr, ir_pc,
//   fetch_count included). A response arriving after reset is ignored.
// - Decoded outputs: imem_req_valid = (state==REQ); ir_valid = (state==HOLD).
// - pc_advance = HOLD & ir_ready & !flush. It is combinational, so the PC
//   updates on the same edge as the handshake.
// - IDLE
//   - flush has priority: stay IDLE.
//   - Else fetch_go with pc_in[1:0]!=0: fetch_fault=1 next cycle, stay IDLE,
//     no request issued.
//   - Else fetch_go: latch pc_in into imem_req_addr and ir_pc; go REQ.
// - REQ
//   - imem_req_addr is held stable until accepted.
//   - req_ready & !flush -> WAIT.
//   - req_ready & flush  -> DRAIN.
//   - !req_ready & flush -> IDLE; the request is withdrawn.
// - WAIT
//   - A cycle counter runs from 0.
//   - rsp_valid & !flush -> capture imem_rsp_data into ir_instr; go HOLD.
//   - rsp_valid & flush  -> drop the data; go IDLE.
//   - flush without rsp  -> DRAIN.
//   - Counter reaches TIMEOUT_CYCLES-1 with no rsp -> fetch_timeout=1 next
//     cycle; go IDLE.
// - DRAIN: wait for rsp_valid, discard it, go IDLE. The timeout also applies
//   here and pulses fetch_timeout.
// - HOLD
//   - ir_instr and ir_pc are held stable.
//   - ir_ready & !flush -> pc_advance=1, fetch_count+=1, go IDLE.
//   - flush -> IDLE; no pc_advance, no count.
// - fetch_go outside IDLE is ignored; the upstream stage retries.
// - Best-case latency: fetch_go @c0 -> req_valid @c1. With ready@c1 and
//   rsp@c2, ir_valid @c3 and the earliest pc_advance @c3.
// - Exactly one outstanding memory request at a time.
//
// TESTING
// - Zero-wait fetch: pc_in=0x100, go@c0, ready@c1, rsp@c2=0x00500093,
//   ir_ready=1 -> ir_valid@c3 with ir_instr=0x00500093, ir_pc=0x100;
//   pc_advance@c3; fetch_count=1.
// - Backpressure: req_ready low 3 cycles, then ir_ready low 2 cycles ->
//   addr stable throughout, ir_instr stable, single pc_advance, count +1.
// - Misaligned: pc_in=0x102, go -> fetch_fault one cycle, imem_req_valid never
//   asserted, pc_advance never asserted.
// - Flush in WAIT: flush@WAIT then rsp 2 cycles later -> DRAIN, data dropped,
//   ir_valid never 1, back in IDLE; the next fetch completes normally.
// - Timeout: TIMEOUT_CYCLES=4, no rsp -> fetch_timeout pulse 4 cycles after
//   entering WAIT, IDLE; a late rsp is ignored.
// - Reset in HOLD and counter wrap: reset -> ir_valid=0, count=0; with CNT_W=2,
//   4 retires -> fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Purpose : fetch stage; takes the PC on fetch_go, issues one valid/ready
//           read to instruction memory and holds the returned word for decode.
// Latency : fetch_go -> req_valid in 1 cycle. With zero memory wait, ir_valid
//           and the earliest pc_advance come 3 cycles after fetch_go.
// Backpressure: imem_req_addr is held until imem_req_ready. ir_instr/ir_pc are
//           held until ir_ready. fetch_go is ignored outside IDLE.
// Ports   : clk/reset (synchronous, active-high); pc_in/fetch_go/flush from
//           the PC stage; imem_req_* and imem_rsp_* to instruction memory;
//           ir_* to decode; pc_advance is the PC enable; fetch_fault and
//           fetch_timeout are 1-cycle status pulses; fetch_count counts
//           retired fetches.
module instruction_fetch_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             fetch_go,
  input  logic             flush,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [XLEN-1:0]  ir_instr,
  output logic [XLEN-1:0]  ir_pc,
  output logic             pc_advance,
  output logic             fetch_fault,
  output logic             fetch_timeout,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              fault_q, fault_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      tcnt_q  <= '0;
      fault_q <= 1'b0;
      tmo_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      tcnt_q  <= tcnt_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

  // Combinational so the PC register updates on the decode handshake edge.
  assign advance = (state_q == HOLD) && ir_ready && !flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = 1'b0;
    tmo_d   = 1'b0;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (fetch_go && (pc_in[1:0] != 2'b00)) begin
          fault_d = 1'b1;
        end else if (fetch_go) begin
          pc_d    = pc_in;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_req_ready) state_d = flush ? DRAIN : WAIT;
        else if (flush)     state_d = IDLE;  // request withdrawn, never accepted
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            instr_d = imem_rsp_data;
            state_d = HOLD;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end else if (tcnt_q == TMAX) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // The accepted request still owes one beat; swallow it.
        if (imem_rsp_valid) begin
          state_d = IDLE;
        end else if (tcnt_q == TMAX) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (ir_ready) begin
          count_d = count_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout counter restarts on entry to WAIT and again on entry to DRAIN,
    // so a flushed fetch gets a fresh budget for its trailing response.
    if (((state_q == WAIT) || (state_q == DRAIN)) && (state_d == state_q))
      tcnt_d = tcnt_q + 1'b1;
    else
      tcnt_d = '0;
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign ir_valid       = (state_q == HOLD);
  assign ir_instr       = instr_q;
  assign ir_pc          = pc_q;
  assign pc_advance     = advance;
  assign fetch_fault    = fault_q;
  assign fetch_timeout  = tmo_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with TIMEOUT_CYCLES=4, CNT_W=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units
// later, well clear of the next edge.
module tb_instruction_fetch_unit;

  localparam int XLEN = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  pc_in;
  logic             fetch_go;
  logic             flush;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_rsp_valid;
  logic [XLEN-1:0]  imem_rsp_data;
  logic             ir_valid;
  logic             ir_ready;
  logic [XLEN-1:0]  ir_instr;
  logic [XLEN-1:0]  ir_pc;
  logic             pc_advance;
  logic             fetch_fault;
  logic             fetch_timeout;
  logic [CNT_W-1:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .XLEN(XLEN), .TIMEOUT_CYCLES(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_go(fetch_go), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_instr(ir_instr), .ir_pc(ir_pc), .pc_advance(pc_advance),
    .fetch_fault(fetch_fault), .fetch_timeout(fetch_timeout),
    .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Zero-wait fetch with decode ready; leaves the unit in IDLE.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
    pc_in = pc; fetch_go = 1'b1; ir_ready = 1'b1;
    tick();
    fetch_go = 1'b0; imem_req_ready = 1'b1;
    settle(); check("f_req_addr", imem_req_addr, pc);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = data;
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    check("f_instr", ir_instr, data);
    check("f_adv", 32'(pc_advance), 32'd1);
    tick();
  endtask

  initial begin
    reset = 1'b1; pc_in = '0; fetch_go = 1'b0; flush = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    ir_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_addr",      imem_req_addr, 32'd0);
    check("rst_ir_valid",  32'(ir_valid), 32'd0);
    check("rst_instr",     ir_instr, 32'd0);
    check("rst_count",     32'(fetch_count), 32'd0);
    tick();

    // Zero-wait fetch, cycle by cycle.
    pc_in = 32'h100; fetch_go = 1'b1; ir_ready = 1'b1;
    settle(); check("zw_c0_req", 32'(imem_req_valid), 32'd0);
    tick();
    fetch_go = 1'b0; imem_req_ready = 1'b1;
    settle();
    check("zw_c1_req",  32'(imem_req_valid), 32'd1);
    check("zw_c1_addr", imem_req_addr, 32'h100);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093;
    settle();
    check("zw_c2_req", 32'(imem_req_valid), 32'd0);
    check("zw_c2_ir",  32'(ir_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    check("zw_c3_ir",    32'(ir_valid), 32'd1);
    check("zw_c3_instr", ir_instr, 32'h00500093);
    check("zw_c3_pc",    ir_pc, 32'h100);
    check("zw_c3_adv",   32'(pc_advance), 32'd1);
    tick();
    ir_ready = 1'b0;
    settle();
    check("zw_c4_ir",    32'(ir_valid), 32'd0);
    check("zw_c4_adv",   32'(pc_advance), 32'd0);
    check("zw_c4_count", 32'(fetch_count), 32'd1);
    tick();

    // Backpressure on both handshakes.
    pc_in = 32'h200; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0; pc_in = 32'hFFFF_FFF0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_req_held", 32'(imem_req_valid), 32'd1);
      check("bp_addr",     imem_req_addr, 32'h200);
      tick();
    end
    imem_req_ready = 1'b1;
    settle(); check("bp_addr_acc", imem_req_addr, 32'h200);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bp_hold_ir",    32'(ir_valid), 32'd1);
      check("bp_hold_instr", ir_instr, 32'hDEADBEEF);
      check("bp_hold_adv",   32'(pc_advance), 32'd0);
      tick();
    end
    ir_ready = 1'b1;
    settle();
    check("bp_adv",   32'(pc_advance), 32'd1);
    check("bp_pc",    ir_pc, 32'h200);
    tick();
    ir_ready = 1'b0;
    settle();
    check("bp_adv_once", 32'(pc_advance), 32'd0);
    check("bp_count",    32'(fetch_count), 32'd2);
    tick();

    // Misaligned PC.
    pc_in = 32'h102; fetch_go = 1'b1; ir_ready = 1'b1;
    settle(); check("mis_c0_fault", 32'(fetch_fault), 32'd0);
    tick();
    fetch_go = 1'b0;
    settle();
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_req",   32'(imem_req_valid), 32'd0);
    check("mis_adv",   32'(pc_advance), 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      check("mis_fault_off", 32'(fetch_fault), 32'd0);
      check("mis_req_off",   32'(imem_req_valid), 32'd0);
      tick();
    end

    // Flush in WAIT, response two cycles later lands in DRAIN.
    pc_in = 32'h300; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b1;
    settle(); check("fl_wait_ir", 32'(ir_valid), 32'd0);
    tick();
    flush = 1'b0;
    settle(); check("fl_drain_ir", 32'(ir_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000BAD;
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    check("fl_after_ir",  32'(ir_valid), 32'd0);
    check("fl_after_adv", 32'(pc_advance), 32'd0);
    do_fetch(32'h304, 32'h00000013);
    check("fl_count", 32'(fetch_count), 32'd3);

    // Timeout: 4 cycles in WAIT with no response.
    pc_in = 32'h400; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("to_wait_pulse", 32'(fetch_timeout), 32'd0);
      tick();
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000777;
    settle();
    check("to_pulse",   32'(fetch_timeout), 32'd1);
    check("to_idle_ir", 32'(ir_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    check("to_pulse_off", 32'(fetch_timeout), 32'd0);
    check("to_late_ir",   32'(ir_valid), 32'd0);
    check("to_instr",     ir_instr, 32'h00000013);
    check("to_count",     32'(fetch_count), 32'd3);
    tick();

    // Fourth retire wraps the 2-bit counter.
    do_fetch(32'h500, 32'h11111111);
    check("wrap_count", 32'(fetch_count), 32'd0);
    do_fetch(32'h504, 32'h22222222);
    check("wrap_count1", 32'(fetch_count), 32'd1);

    // Reset while holding an instruction; a late response is then ignored.
    ir_ready = 1'b0; pc_in = 32'h600; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h33333333;
    tick();
    imem_rsp_valid = 1'b0;
    settle(); check("hr_hold_ir", 32'(ir_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h44444444;
    settle();
    check("hr_ir",    32'(ir_valid), 32'd0);
    check("hr_count", 32'(fetch_count), 32'd0);
    check("hr_pc",    ir_pc, 32'd0);
    check("hr_instr", ir_instr, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    check("hr_late_ir",    32'(ir_valid), 32'd0);
    check("hr_late_instr", ir_instr, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
